// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg -- definitions shared between the APB master and the CSR slave.
//
// Contents:
//   APB_ADDR_W       default APB address width
//   APB_DATA_W       default APB data width
//   apb_mst_state_e  APB master FSM state encoding (IDLE, SETUP, ACCESS, RESP)
// -----------------------------------------------------------------------------
package snn_pkg;

  localparam int APB_ADDR_W = 16;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

endpackage : snn_pkg

// File: rtl/snn_apb_master.sv
// -----------------------------------------------------------------------------
// snn_apb_master -- single-outstanding APB master.
//
// A command (valid/ready) is turned into one APB transfer
// (SETUP -> ACCESS ... ACCESS); the result is returned as a response
// (valid/ready) that must be consumed before the next command is accepted.
//
// Parameters:
//   ADDR_W       APB address width
//   DATA_W       APB data width
//   TIMEOUT_CYC  maximum ACCESS cycles waiting for pready (watchdog build only)
//
// Ports:
//   clk, rst_n                         clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_write, cmd_addr, cmd_wdata     command payload
//   rsp_valid/rsp_ready                response handshake
//   rsp_rdata, rsp_err                 response payload (rdata is 0 for writes)
//   psel, penable, pwrite, paddr,
//   pwdata, prdata, pready             APB requester interface
//
// Configuration:
//   SNN_APB_MST_TIMEOUT_EN  when defined, an ACCESS phase that sees no pready
//                           for TIMEOUT_CYC cycles is abandoned and answered
//                           with rsp_err=1, rsp_rdata=0. When undefined, ACCESS
//                           waits indefinitely and rsp_err is always 0.
// -----------------------------------------------------------------------------
module snn_apb_master
  import snn_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // APB
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  apb_mst_state_e state_reg;
  apb_mst_state_e state_next;

  logic cmd_fire;   // command accepted this cycle
  logic xfer_done;  // slave completed the ACCESS phase this cycle

`ifdef SNN_APB_MST_TIMEOUT_EN
  // Wide enough to hold TIMEOUT_CYC itself: the counter reaches that value
  // on the cycle the transfer is abandoned.
  localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             tmo_hit;   // this pready=0 cycle is the last one allowed
  logic             xfer_tmo;  // ACCESS abandoned this cycle
  logic             rsp_err_reg;

  assign tmo_hit = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded outputs. psel/penable/rsp_valid/cmd_ready
  // come straight from the state register, so an asynchronous reset drops
  // them in the same cycle without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    rsp_valid  = 1'b0;
    cmd_fire   = 1'b0;
    xfer_done  = 1'b0;
`ifdef SNN_APB_MST_TIMEOUT_EN
    xfer_tmo   = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_fire   = 1'b1;
          state_next = SETUP;
        end
      end

      SETUP: begin
        psel       = 1'b1;
        state_next = ACCESS;
      end

      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          xfer_done  = 1'b1;
          state_next = RESP;
        end
`ifdef SNN_APB_MST_TIMEOUT_EN
        else if (tmo_hit) begin
          xfer_tmo   = 1'b1;
          state_next = RESP;
        end
`endif
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // APB request registers: loaded only on command acceptance, so they stay
  // stable for the whole transfer and keep their last value afterwards.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (cmd_fire) begin
      pwrite <= cmd_write;
      paddr  <= cmd_addr;
      pwdata <= cmd_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Response data: written only when ACCESS ends, hence stable through RESP.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
    end else if (xfer_done) begin
      rsp_rdata <= pwrite ? '0 : prdata;
    end
`ifdef SNN_APB_MST_TIMEOUT_EN
    else if (xfer_tmo) begin
      rsp_rdata <= '0;
    end
`endif
  end

`ifdef SNN_APB_MST_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // ACCESS watchdog: cleared when a command moves the FSM to SETUP, counts
  // each ACCESS cycle that the slave leaves pready low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg <= '0;
    end else if (cmd_fire) begin
      tmo_cnt_reg <= '0;
    end else if ((state_reg == ACCESS) && !pready) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_reg <= 1'b0;
    end else if (xfer_done) begin
      rsp_err_reg <= 1'b0;
    end else if (xfer_tmo) begin
      rsp_err_reg <= 1'b1;
    end
  end

  assign rsp_err = rsp_err_reg;
`else
  // Without the watchdog a transfer can only end on pready.
  assign rsp_err = 1'b0;

  // TIMEOUT_CYC stays on the interface so both builds share one parameter
  // list; it has no effect here.
  if (TIMEOUT_CYC < 1) begin : g_timeout_cfg_unused
  end
`endif

endmodule : snn_apb_master

// File: tb/tb_snn_apb_master.sv
// -----------------------------------------------------------------------------
// tb_snn_apb_master -- self-checking bench for snn_apb_master.
//
// A small APB slave (word memory plus cntrl_status_csr at 0x3000, programmable
// wait states) answers the master. For each command the bench computes, from
// the handshake cycle, the wait-state count and the response back-pressure,
// the per-cycle expected values of every DUT output; a compare process checks
// them on every falling edge. Directed transfers add literal expectations.
// Build with SNN_APB_MST_TIMEOUT_EN defined to exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_snn_apb_master;

  localparam int TB_TIMEOUT = 8;
  localparam int NCYC       = 2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite, pready;
  logic [15:0] paddr;
  logic [31:0] pwdata, prdata;

  always #5 clk = ~clk;

  snn_apb_master #(
    .ADDR_W     (16),
    .DATA_W     (32),
    .TIMEOUT_CYC(TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit model_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- APB slave
  logic [31:0] slave_mem [0:255] = '{default: 32'h0};
  logic [31:0] cntrl_status_csr = 32'h0;
  int          access_cnt  = 0;
  int          slave_waits = 0;

  assign pready = (access_cnt >= slave_waits);
  always_comb prdata = (paddr == 16'h3000) ? cntrl_status_csr : slave_mem[paddr[9:2]];

  always @(posedge clk) begin
    if (psel && penable && pready && pwrite) begin
      if (paddr == 16'h3000) cntrl_status_csr <= pwdata;
      else                   slave_mem[paddr[9:2]] <= pwdata;
    end
    if (psel && penable && !pready) access_cnt <= access_cnt + 1;
    else if (!psel)                 access_cnt <= 0;
  end

  // ------------------------------------------------------------------- model
  bit          exp_ready [NCYC];
  bit          exp_psel  [NCYC];
  bit          exp_pen   [NCYC];
  bit          exp_rv    [NCYC];
  bit          exp_wr    [NCYC];
  bit          exp_err   [NCYC];
  logic [15:0] exp_addr  [NCYC];
  logic [31:0] exp_wdata [NCYC];
  logic [31:0] exp_rdata [NCYC];
  logic [31:0] model_mem [logic [15:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Everything from cycle 'from' onward: idle, request registers at reset value.
  task automatic model_clear(input int from);
    for (int c = from; c < NCYC; c++) begin
      exp_ready[c] = 1'b1;
      exp_psel[c]  = 1'b0;
      exp_pen[c]   = 1'b0;
      exp_rv[c]    = 1'b0;
      exp_wr[c]    = 1'b0;
      exp_err[c]   = 1'b0;
      exp_addr[c]  = 16'h0;
      exp_wdata[c] = 32'h0;
      exp_rdata[c] = 32'h0;
    end
  endtask

  always @(negedge clk) begin
    if (model_on && rst_n && cyc < NCYC) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready[cyc]));
      chk("psel",      32'(psel),      32'(exp_psel[cyc]));
      chk("penable",   32'(penable),   32'(exp_pen[cyc]));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv[cyc]));
      chk("pwrite",    32'(pwrite),    32'(exp_wr[cyc]));
      chk("paddr",     32'(paddr),     32'(exp_addr[cyc]));
      chk("pwdata",    pwdata,         exp_wdata[cyc]);
      if (exp_rv[cyc]) begin
        chk("rsp_rdata", rsp_rdata,    exp_rdata[cyc]);
        chk("rsp_err",   32'(rsp_err), 32'(exp_err[cyc]));
      end
    end
  end

  // One command from an IDLE cycle to response consumption. 'waits' is the
  // number of ACCESS cycles the slave holds pready low, 'rdelay' the number of
  // RESP cycles with rsp_ready low. With hold_valid the requester keeps
  // cmd_valid high after acceptance (its next command is already waiting).
  task automatic do_xfer(input bit wr, input logic [15:0] addr, input logic [31:0] wdata,
                         input int waits, input int rdelay, input bit hold_valid,
                         input logic [31:0] lit_rdata, input bit lit_err);
    int          n, acc, resp_start, take;
    bit          err;
    logic [31:0] rdata;
    n = cyc;
`ifdef SNN_APB_MST_TIMEOUT_EN
    err = (waits >= TB_TIMEOUT);
    acc = err ? TB_TIMEOUT : waits + 1;
`else
    err = 1'b0;
    acc = waits + 1;
`endif
    if (wr || err)                rdata = 32'h0;
    else if (model_mem.exists(addr)) rdata = model_mem[addr];
    else                          rdata = 32'h0;
    if (wr && !err) model_mem[addr] = wdata;
    resp_start = n + 2 + acc;
    take       = resp_start + rdelay;
    if (take + 2 >= NCYC) begin
      $display("FAIL cycle_budget cyc=%0d actual=%0d required<%0d", cyc, take, NCYC);
      $fatal(1, "cycle budget exceeded");
    end
    for (int c = n + 1; c <= take; c++) begin
      exp_ready[c] = 1'b0;
      exp_psel[c]  = (c <= n + 1 + acc);
      exp_pen[c]   = (c >= n + 2) && (c <= n + 1 + acc);
      exp_rv[c]    = (c >= resp_start);
      exp_rdata[c] = rdata;
      exp_err[c]   = err;
    end
    for (int c = n + 1; c < NCYC; c++) begin
      exp_addr[c]  = addr;
      exp_wr[c]    = wr;
      exp_wdata[c] = wdata;
    end

    slave_waits = waits;
    cmd_write   = wr;
    cmd_addr    = addr;
    cmd_wdata   = wdata;
    cmd_valid   = 1'b1;
    while (cyc < take) begin
      @(posedge clk);
      #1;
      if (!hold_valid) cmd_valid = 1'b0;
      if (cyc == n + 1) chk("setup_phase",  32'({psel, penable}), 32'h2);
      if (cyc == n + 2) chk("access_phase", 32'({psel, penable}), 32'h3);
`ifndef SNN_APB_MST_TIMEOUT_EN
      if (waits >= 100 && cyc == n + 101) chk("access_after_100", 32'({psel, penable}), 32'h3);
`endif
      if (cyc == take) rsp_ready = 1'b1;
    end
    chk("rsp_valid_lit", 32'(rsp_valid), 32'h1);
    chk("rsp_rdata_lit", rsp_rdata, lit_rdata);
    chk("rsp_err_lit",   32'(rsp_err), 32'(lit_err));
    $display("xfer %s addr=%h wdata=%h waits=%0d rdelay=%0d rdata=%h err=%0d handshake_cyc=%0d rsp_cyc=%0d",
             wr ? "WR" : "RD", addr, wdata, waits, rdelay, rsp_rdata, rsp_err, n, resp_start);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 16'h0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    model_clear(0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("reset_psel_pen",  32'({psel, penable}), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_paddr",     32'(paddr), 32'h0);
    chk("reset_pwdata",    pwdata, 32'h0);
    chk("reset_pwrite",    32'(pwrite), 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err",   32'(rsp_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_clear(cyc);
    model_on = 1'b1;

    // CSR write, zero wait states
    do_xfer(1'b1, 16'h3000, 32'h0000_0001, 0, 0, 1'b0, 32'h0, 1'b0);
    chk("csr_value", cntrl_status_csr, 32'h0000_0001);

    // write then read back
    do_xfer(1'b1, 16'h0004, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0, 1'b0);
    do_xfer(1'b0, 16'h0004, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // read with five wait states
    do_xfer(1'b1, 16'h0010, 32'h1234_5678, 0, 0, 1'b0, 32'h0, 1'b0);
    do_xfer(1'b0, 16'h0010, 32'h0, 5, 0, 1'b0, 32'h1234_5678, 1'b0);

    // write with wait states and a slow response consumer
    do_xfer(1'b1, 16'h000C, 32'h0BAD_F00D, 2, 1, 1'b0, 32'h0, 1'b0);

    // response held off 3 cycles while the next command is already pending
    do_xfer(1'b0, 16'h0004, 32'h0, 0, 3, 1'b1, 32'hDEAD_BEEF, 1'b0);
    do_xfer(1'b0, 16'h000C, 32'h0, 0, 0, 1'b0, 32'h0BAD_F00D, 1'b0);

    // slave stalls for 100 ACCESS cycles
`ifdef SNN_APB_MST_TIMEOUT_EN
    do_xfer(1'b0, 16'h0010, 32'h0, 100, 0, 1'b0, 32'h0, 1'b1);
`else
    do_xfer(1'b0, 16'h0010, 32'h0, 100, 0, 1'b0, 32'h1234_5678, 1'b0);
`endif

    // asynchronous reset in the middle of ACCESS
    model_on    = 1'b0;
    slave_waits = 50;
    cmd_write   = 1'b0;
    cmd_addr    = 16'h0010;
    cmd_valid   = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_access", 32'({psel, penable}), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_apb", 32'({psel, penable}), 32'h0);
    chk("async_reset_rsp", 32'(rsp_valid), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("post_reset_paddr",     32'(paddr), 32'h0);
    slave_waits = 0;
    model_clear(cyc);
    model_on = 1'b1;

    do_xfer(1'b1, 16'h0008, 32'hA5A5_5A5A, 0, 0, 1'b0, 32'h0, 1'b0);
    do_xfer(1'b0, 16'h0008, 32'h0, 1, 0, 1'b0, 32'hA5A5_5A5A, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    model_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_snn_apb_master
